// File: rtl/chacha_block_ctrl_if.sv
// Handshake, block-counter and datapath-strobe bundle for the ChaCha block controller.
interface chacha_block_ctrl_if #(
    parameter int unsigned CTR_WIDTH = 32
);
    // Request / result handshake
    logic                 start_i;
    logic                 ready_o;
    logic                 busy_o;
    logic                 valid_o;
    logic                 ready_i;

    // Block counter
    logic                 load_ctr_i;
    logic [CTR_WIDTH-1:0] ctr_init_i;
    logic [CTR_WIDTH-1:0] counter_o;
    logic                 ctr_wrap_o;

    // Datapath control
    logic                 init_block_o;
    logic                 set_qr_input_o;
    logic                 get_qr_output_o;
    logic                 rotate_block_o;
    logic                 rotate_direction_o;
    logic                 init_counter_o;
    logic                 incr_counter_o;
    logic                 last_round_i;

    // Controller side
    modport slave (
        input  start_i, ready_i, load_ctr_i, ctr_init_i, last_round_i,
        output ready_o, busy_o, valid_o, counter_o, ctr_wrap_o,
               init_block_o, set_qr_input_o, get_qr_output_o, rotate_block_o,
               rotate_direction_o, init_counter_o, incr_counter_o
    );

    // Requester / datapath side
    modport master (
        output start_i, ready_i, load_ctr_i, ctr_init_i, last_round_i,
        input  ready_o, busy_o, valid_o, counter_o, ctr_wrap_o,
               init_block_o, set_qr_input_o, get_qr_output_o, rotate_block_o,
               rotate_direction_o, init_counter_o, incr_counter_o
    );
endinterface

// File: rtl/chacha_block_ctrl.sv
// Control FSM for the ChaCha block datapath: load, ROUND_COUNT double rounds,
// then hold the permuted block under a valid/ready handshake. Owns the block counter.
module chacha_block_ctrl #(
    parameter int unsigned ROUND_COUNT = 10,
    parameter int unsigned CTR_WIDTH   = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    chacha_block_ctrl_if.slave bus
);
    localparam int unsigned RND_W = $clog2(ROUND_COUNT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_COL   = 3'd2,
        ST_DLOAD = 3'd3,
        ST_DIAG  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CTR_WIDTH-1:0] counter;
    logic                 ctr_wrap;
    logic                 ready;
    logic                 busy;
    logic                 valid;
    logic                 init_block;
    logic                 set_qr_reg;
    logic                 get_qr;
    logic                 rotate_block;
    logic                 rotate_dir;
    logic                 init_counter;
    logic                 incr_counter;
    logic [RND_W-1:0]     rounds;

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (bus.start_i) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_COL;
            ST_COL:   state_nxt = ST_DLOAD;
            ST_DLOAD: state_nxt = ST_DIAG;
            ST_DIAG:  state_nxt = ST_NEXT;
            ST_NEXT:  state_nxt = bus.last_round_i ? ST_DONE : ST_COL;
            ST_DONE:  if (bus.ready_i) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, registered Moore strobes (decoded from the next state) and block counter
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state        <= ST_IDLE;
            counter      <= '0;
            ctr_wrap     <= 1'b0;
            ready        <= 1'b1;
            busy         <= 1'b0;
            valid        <= 1'b0;
            init_block   <= 1'b0;
            set_qr_reg   <= 1'b0;
            get_qr       <= 1'b0;
            rotate_block <= 1'b0;
            rotate_dir   <= 1'b0;
            init_counter <= 1'b0;
            incr_counter <= 1'b0;
            rounds       <= '0;
        end else begin
            state        <= state_nxt;
            ready        <= (state_nxt == ST_IDLE);
            busy         <= (state_nxt inside {ST_LOAD, ST_COL, ST_DLOAD, ST_DIAG, ST_NEXT});
            valid        <= (state_nxt == ST_DONE);
            init_block   <= (state_nxt == ST_LOAD);
            set_qr_reg   <= (state_nxt == ST_LOAD) || (state_nxt == ST_DLOAD);
            get_qr       <= (state_nxt == ST_COL) || (state_nxt == ST_DIAG);
            rotate_block <= (state_nxt == ST_COL) || (state_nxt == ST_DIAG);
            rotate_dir   <= (state_nxt == ST_DIAG);
            init_counter <= (state_nxt == ST_LOAD);
            incr_counter <= (state_nxt == ST_DIAG);
            ctr_wrap     <= 1'b0;

            if (state == ST_IDLE && bus.load_ctr_i) begin
                counter <= bus.ctr_init_i;
            end else if (state == ST_DONE && bus.ready_i) begin
                counter  <= counter + CTR_WIDTH'(1);
                ctr_wrap <= &counter;
            end

            if (state == ST_LOAD) begin
                rounds <= '0;
            end else if (state == ST_DIAG) begin
                rounds <= rounds + RND_W'(1);
            end
        end
    end

    // The datapath round counter and ours must agree when it reports the last round
    always_ff @(posedge clk_i) begin
        if (rst_i && state == ST_NEXT && bus.last_round_i) begin
            assert (rounds == RND_W'(ROUND_COUNT))
                else $error("last_round_i after %0d double rounds", rounds);
        end
    end

    assign bus.ready_o            = ready;
    assign bus.busy_o             = busy;
    assign bus.valid_o            = valid;
    assign bus.counter_o          = counter;
    assign bus.ctr_wrap_o         = ctr_wrap;
    assign bus.init_block_o       = init_block;
    // last_round_i only settles in NEXT (one cycle after the increment), so the
    // re-arm of the next column round cannot be registered ahead of time.
    assign bus.set_qr_input_o     = set_qr_reg | ((state == ST_NEXT) & ~bus.last_round_i);
    assign bus.get_qr_output_o    = get_qr;
    assign bus.rotate_block_o     = rotate_block;
    assign bus.rotate_direction_o = rotate_dir;
    assign bus.init_counter_o     = init_counter;
    assign bus.incr_counter_o     = incr_counter;
endmodule
